dht11_req_sched: RTL and testbench
==================================

Name: dht11_req_sched

Overview:
- Scheduler in front of the single-wire DHT11 read engine; one sensor transaction at a time.
- Arbitrates read requests from two clients (A = host/UART command path, B = display/logging path) with round-robin priority.
- Enforces the sensor's minimum inter-transaction gap and applies a per-transaction timeout.
- Retries on checksum failure or timeout, and serves recent good readings from a result cache without touching the bus.
- Sits between client logic and the DHT11 engine; runs on the 1 MHz sensor clock domain with a 1 us tick input.

Parameters:
- MIN_GAP_US, 2_000_000, minimum ticks from one engine completion (or reset) to the next eng_start; also the cache lifetime.
- TIMEOUT_US, 30_000, ticks allowed from eng_start to eng_done before the attempt is abandoned.
- MAX_RETRY, 2, extra attempts after the first failed attempt (range 0..7).

Ports:
- clk, input, 1, block clock.
- rst_n, input, 1, asynchronous active-low reset.
- tick_1us, input, 1, single-cycle strobe once per microsecond; all time counters advance only on it.
- req_a_valid / req_b_valid, input, 1 each, read request, held until accepted.
- req_a_ready / req_b_ready, output, 1 each, request accepted this cycle (valid & ready).
- rsp_valid, output, 1, one-cycle response strobe.
- rsp_id, output, 1, response owner: 0 = A, 1 = B.
- rsp_data, output, 32, {hum_int, hum_dec, temp_int, temp_dec}.
- rsp_err, output, 1, all attempts failed; rsp_data is 0.
- rsp_cached, output, 1, response served from the cache.
- eng_start, output, 1, one-cycle start pulse to the engine.
- eng_done, input, 1, one-cycle completion pulse from the engine.
- eng_data, input, 32, engine payload, valid with eng_done.
- eng_crc_ok, input, 1, checksum good, valid with eng_done.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
Reset values:
- All outputs 0; state IDLE; gap_cnt 0; cache_valid 0; rr_ptr 0 (A favoured first).

Arbitration (IDLE only):
- If both clients request, the one rr_ptr points to wins; rr_ptr then flips to the other client.
- If only one client requests, it wins and rr_ptr still flips to the other client.
- ready is asserted to the winner for exactly one cycle; the owner id is latched.
- No request is accepted outside IDLE.

Cache:
- cache_age counts ticks since the last good capture and saturates at MIN_GAP_US.
- Hit = cache_valid & cache_age < MIN_GAP_US.
- On a hit, the request is answered the cycle after acceptance: rsp_valid=1, rsp_cached=1, rsp_data=cache. State stays IDLE.

States:
- IDLE -> GAP on acceptance with a cache miss.
- GAP -> START when gap_cnt >= MIN_GAP_US. gap_cnt counts ticks since the last eng_done or reset and saturates at MIN_GAP_US.
- START: eng_start=1 for one cycle; clear to_cnt; -> BUSY.
- BUSY -> CHECK on eng_done.
- BUSY -> FAIL when to_cnt reaches TIMEOUT_US-1 on a tick. gap_cnt is cleared, as for a done.
- CHECK, crc ok: write the cache, set cache_valid, clear cache_age, respond (rsp_cached=0) -> IDLE.
- CHECK, crc bad -> FAIL.
- FAIL with retry_cnt < MAX_RETRY: retry_cnt++ -> GAP.
- FAIL otherwise: respond rsp_err=1, rsp_data=0 -> IDLE. retry_cnt is cleared on each new acceptance.

Response timing:
- rsp_valid goes high the cycle after CHECK or FAIL completes and lasts one cycle.
- rsp_id equals the latched owner.

Edge cases:
- eng_done arriving in the same cycle as the timeout tick counts as done; timeout is not taken.
- eng_done outside BUSY is ignored, but it still clears gap_cnt.
- When tick_1us and acceptance coincide, counters update normally.
- Reset asserted mid-transaction returns to IDLE immediately and drops any pending response.

Width rules:
- Counters are sized by $clog2(param+1).
- Counters saturate and never wrap.

Optional Feature:
- Macro DHT11_SCHED_AUTOPOLL_EN.
- Defined: when IDLE with no request and gap_cnt reaches MIN_GAP_US, the block starts an internal refresh transaction.
- The refresh follows the normal sequence with retries. It updates the cache only and produces no rsp_valid.
- A client request arriving during the refresh waits (ready low) and is then served from the fresh cache.
- Undefined: the sensor is accessed only on a cache miss.

Test Plan:
(All with MIN_GAP_US=100, TIMEOUT_US=50, MAX_RETRY=2, tick every 4 clk.)
- A requests after reset; engine returns done, crc_ok, data 0x3A002100 after 20 ticks -> eng_start at tick 100; rsp_valid with id=0, data=0x3A002100, cached=0, err=0.
- B requests 30 ticks after that response -> rsp one cycle after acceptance, id=1, data=0x3A002100, cached=1, no eng_start.
- A and B assert in the same cycle with rr_ptr=0 -> A accepted first and B on the next IDLE. After B's response, rr_ptr=0.
- Engine returns crc_ok=0 twice, then good data 0x28001900 -> exactly 3 eng_start pulses, each at least 100 ticks after the previous done; one response with data=0x28001900.
- Engine never asserts done -> 3 timeouts of 50 ticks each; rsp_err=1, data=0; busy drops the cycle after the response.
- rst_n pulsed low while in BUSY -> outputs 0 and state IDLE asynchronously; no rsp_valid; the next request waits the full 100-tick gap.

Source files
------------

// File: rtl/dht11_req_sched.sv
// Round-robin request scheduler for a DHT11 read engine: gap/timeout timing, retries, result cache.
// Optional DHT11_SCHED_AUTOPOLL_EN adds an internal cache refresh whenever the bus is idle long enough.
module dht11_req_sched #(
  parameter int unsigned MIN_GAP_US = 2_000_000,
  parameter int unsigned TIMEOUT_US = 30_000,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1us,
  input  logic        req_a_valid,
  input  logic        req_b_valid,
  output logic        req_a_ready,
  output logic        req_b_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_cached,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic [31:0] eng_data,
  input  logic        eng_crc_ok,
  output logic        busy
);

  localparam int GAP_W = $clog2(MIN_GAP_US + 1);
  localparam int TO_W  = $clog2(TIMEOUT_US + 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(MIN_GAP_US);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_US - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_START, S_BUSY, S_CHECK, S_FAIL, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]  cache_age_q, cache_age_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [2:0]        retry_cnt_q, retry_cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic              refresh_q, refresh_d;
  logic              cache_valid_q, cache_valid_d;
  logic              cap_ok_q, cap_ok_d;
  logic [31:0]       cache_data_q, cache_data_d;
  logic [31:0]       cap_data_q, cap_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_cached_q, rsp_cached_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic grant_a, grant_b, hit;

  always_comb begin
    grant_a = req_a_valid & (~req_b_valid | ~rr_ptr_q);
    grant_b = req_b_valid & (~req_a_valid | rr_ptr_q);
    hit     = cache_valid_q & (cache_age_q < GAP_MAX);
  end

  assign req_a_ready = (state_q == S_IDLE) & grant_a;
  assign req_b_ready = (state_q == S_IDLE) & grant_b;
  assign eng_start   = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_cached  = rsp_cached_q;

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    cache_age_d   = cache_age_q;
    to_cnt_d      = to_cnt_q;
    retry_cnt_d   = retry_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    refresh_d     = refresh_q;
    cache_valid_d = cache_valid_q;
    cache_data_d  = cache_data_q;
    cap_data_d    = cap_data_q;
    cap_ok_d      = cap_ok_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_cached_d  = 1'b0;
    rsp_data_d    = '0;

    if (tick_1us && gap_cnt_q != GAP_MAX) gap_cnt_d = gap_cnt_q + 1'b1;
    // Any completion pulse restarts the sensor recovery gap, even a stray one.
    if (eng_done) gap_cnt_d = '0;
    if (tick_1us && cache_age_q != GAP_MAX) cache_age_d = cache_age_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          rr_ptr_d = grant_a;
          if (hit) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant_b;
            rsp_cached_d = 1'b1;
            rsp_data_d   = cache_data_q;
          end else begin
            owner_d     = grant_b;
            retry_cnt_d = '0;
            refresh_d   = 1'b0;
            state_d     = S_GAP;
          end
        end
`ifdef DHT11_SCHED_AUTOPOLL_EN
        else if (gap_cnt_q == GAP_MAX) begin
          refresh_d   = 1'b1;
          retry_cnt_d = '0;
          state_d     = S_GAP;
        end
`endif
      end
      S_GAP:   if (gap_cnt_q == GAP_MAX) state_d = S_START;
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_BUSY;
      end
      S_BUSY: begin
        // A done coinciding with the final timeout tick wins over the timeout.
        if (eng_done) begin
          cap_data_d = eng_data;
          cap_ok_d   = eng_crc_ok;
          state_d    = S_CHECK;
        end else if (tick_1us) begin
          if (to_cnt_q == TO_LAST) begin
            gap_cnt_d = '0;
            state_d   = S_FAIL;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (cap_ok_q) begin
          cache_data_d  = cap_data_q;
          cache_valid_d = 1'b1;
          cache_age_d   = '0;
          rsp_valid_d   = ~refresh_q;
          rsp_id_d      = owner_q & ~refresh_q;
          rsp_data_d    = refresh_q ? 32'd0 : cap_data_q;
          state_d       = S_RESP;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_FAIL: begin
        if (retry_cnt_q < RETRY_MAX) begin
          retry_cnt_d = retry_cnt_q + 3'd1;
          state_d     = S_GAP;
        end else begin
          rsp_valid_d = ~refresh_q;
          rsp_id_d    = owner_q & ~refresh_q;
          rsp_err_d   = ~refresh_q;
          state_d     = S_RESP;
        end
      end
      // Holds busy high while the response strobe is on the outputs.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gap_cnt_q     <= '0;
      cache_age_q   <= '0;
      to_cnt_q      <= '0;
      retry_cnt_q   <= '0;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      refresh_q     <= 1'b0;
      cache_valid_q <= 1'b0;
      cap_ok_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_cached_q  <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      cache_age_q   <= cache_age_d;
      to_cnt_q      <= to_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      refresh_q     <= refresh_d;
      cache_valid_q <= cache_valid_d;
      cap_ok_q      <= cap_ok_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_err_q     <= rsp_err_d;
      rsp_cached_q  <= rsp_cached_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  // Payload registers are qualified by cache_valid_q / state and need no reset.
  always_ff @(posedge clk) begin
    cache_data_q <= cache_data_d;
    cap_data_q   <= cap_data_d;
  end

endmodule

// File: tb/tb_dht11_req_sched.sv
// Bench for dht11_req_sched: directed test-plan steps then randomized transactions against a timing/cache model.
module tb_dht11_req_sched;
  localparam int MIN_GAP = 100;
  localparam int TMO     = 50;
  localparam int MAXR    = 2;

  logic        clk = 1'b0;
  logic        rst_n, tick_1us, req_a_valid, req_b_valid;
  logic        eng_done, eng_crc_ok;
  logic [31:0] eng_data;
  logic        req_a_ready, req_b_ready, rsp_valid, rsp_id, rsp_err, rsp_cached;
  logic        eng_start, busy;
  logic [31:0] rsp_data;

  int checks = 0, errors = 0;
  int tick_count;
  int starts = 0, last_start = 0, last_end = 0, rsp_count = 0;
  int m_rr = 0;
  bit m_cache_valid = 0;
  logic [31:0] m_cache_data = '0;
  int m_cache_tick = 0;

  typedef struct { int kind; int lat; logic [31:0] data; } beh_t;  // kind: 0 good, 1 bad crc, 2 no reply
  beh_t eng_q[$];

  dht11_req_sched #(.MIN_GAP_US(MIN_GAP), .TIMEOUT_US(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1us(tick_1us),
    .req_a_valid(req_a_valid), .req_b_valid(req_b_valid),
    .req_a_ready(req_a_ready), .req_b_ready(req_b_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_cached(rsp_cached),
    .eng_start(eng_start), .eng_done(eng_done), .eng_data(eng_data),
    .eng_crc_ok(eng_crc_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    tick_1us = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_1us = 1'b1;
      @(negedge clk);
      tick_1us = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tick_count <= 0;
    else if (tick_1us) tick_count <= tick_count + 1;

  always @(posedge clk)
    if (rst_n && rsp_valid) rsp_count <= rsp_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model: replays the scripted outcome queue, one entry per start pulse.
  initial begin
    beh_t b;
    eng_done = 1'b0; eng_data = '0; eng_crc_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_start) begin
        starts++;
        last_start = tick_count;
        check("eng_gap_ge_min", 32'(tick_count - last_end >= MIN_GAP), 1);
        check("eng_start_expected", 32'(eng_q.size() != 0), 1);
        if (eng_q.size() != 0) begin
          b = eng_q.pop_front();
          if (b.kind == 2) begin
            last_end = tick_count + TMO;
          end else begin
            for (int i = 0; i < b.lat * 4; i++) @(negedge clk);
            eng_data = b.data; eng_crc_ok = (b.kind == 0); eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0; eng_data = '0; eng_crc_ok = 1'b0;
            last_end = tick_count;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tick_count;
    while (tick_count - t0 < n) @(negedge clk);
  endtask

  task automatic accept_one(input int who);
    bit ok;
    ok = 0;
    if (who == 0) req_a_valid = 1'b1; else req_b_valid = 1'b1;
    #1;
    for (int i = 0; i < 4000; i++) begin
      if ((who == 0 && req_a_ready) || (who == 1 && req_b_ready)) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    check("accepted", ok, 1);
    @(posedge clk); #1;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(negedge clk);
    m_rr = 1 - who;
  endtask

  task automatic get_rsp(output int waited);
    waited = 0;
    while (!rsp_valid && waited < 4000) begin @(negedge clk); waited++; end
    check("rsp_seen", rsp_valid, 1);
  endtask

  task automatic plan(input int f, input logic [31:0] d, input int kmode);
    int nf;
    beh_t b;
    nf = (f > MAXR) ? MAXR + 1 : f;
    for (int i = 0; i < nf; i++) begin
      b.kind = (kmode == 3) ? int'($urandom_range(1, 2)) : kmode;
      b.lat = int'($urandom_range(1, 40)); b.data = $urandom;
      eng_q.push_back(b);
    end
    if (f <= MAXR) begin
      b.kind = 0; b.lat = int'($urandom_range(1, 40)); b.data = d;
      eng_q.push_back(b);
    end
  endtask

  // f failed attempts precede the good one; more than MAXR failures end in an error response.
  task automatic miss_txn(input int who, input int f, input logic [31:0] d, input int kmode, input string tag);
    int s0, w;
    bit exp_ok;
    s0 = starts;
    plan(f, d, kmode);
    accept_one(who);
    get_rsp(w);
    exp_ok = (f <= MAXR);
    check({tag, "_id"}, rsp_id, who);
    check({tag, "_err"}, rsp_err, !exp_ok);
    check({tag, "_data"}, rsp_data, exp_ok ? d : 32'd0);
    check({tag, "_cached"}, rsp_cached, 0);
    check({tag, "_busy_in_rsp"}, busy, 1);
    check({tag, "_starts"}, starts - s0, exp_ok ? f + 1 : MAXR + 1);
    if (exp_ok) begin m_cache_valid = 1; m_cache_data = d; m_cache_tick = tick_count; end
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_rsp_one_cycle"}, rsp_valid, 0);
  endtask

  task automatic hit_txn(input int who, input string tag);
    int s0, w;
    s0 = starts;
    accept_one(who);
    get_rsp(w);
    check({tag, "_latency"}, w, 0);
    check({tag, "_id"}, rsp_id, who);
    check({tag, "_cached"}, rsp_cached, 1);
    check({tag, "_err"}, rsp_err, 0);
    check({tag, "_data"}, rsp_data, m_cache_data);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_no_start"}, starts - s0, 0);
  endtask

  task automatic both_hit(input string tag);
    int w;
    w = m_rr;
    req_a_valid = 1'b1; req_b_valid = 1'b1;
    #1;
    check({tag, "_ready_a"}, req_a_ready, w == 0);
    check({tag, "_ready_b"}, req_b_ready, w == 1);
    @(posedge clk); #1;
    if (w == 0) req_a_valid = 1'b0; else req_b_valid = 1'b0;
    @(negedge clk); #1;
    check({tag, "_rsp1_id"}, rsp_id, w);
    check({tag, "_rsp1_cached"}, rsp_cached & rsp_valid, 1);
    check({tag, "_loser_ready"}, (w == 0) ? req_b_ready : req_a_ready, 1);
    @(posedge clk); #1;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rsp2_id"}, rsp_id, 1 - w);
    check({tag, "_rsp2_data"}, rsp_data, m_cache_data);
    m_rr = w;
    @(negedge clk);
  endtask

  initial begin
    int s0, rc0, who;
    rst_n = 1'b0; req_a_valid = 1'b0; req_b_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ready", {req_a_ready, req_b_ready}, 0);
    rst_n = 1'b1;

    miss_txn(0, 0, 32'h3A002100, 1, "t1");
    check("t1_start_tick", last_start, MIN_GAP);

    wait_ticks(30);
    hit_txn(1, "t2");

    both_hit("t3a");
    both_hit("t3b");

    wait_ticks(120);
    miss_txn(0, 2, 32'h28001900, 1, "t4");

    wait_ticks(120);
    miss_txn(1, 3, 32'h0, 2, "t5");

    // Reset in the middle of a transaction that is waiting on the engine.
    wait_ticks(120);
    begin
      beh_t b;
      b.kind = 2; b.lat = 0; b.data = '0;
      eng_q.push_back(b);
    end
    s0 = starts;
    accept_one(0);
    for (int i = 0; i < 2000 && starts == s0; i++) @(negedge clk);
    check("t6_started", starts - s0, 1);
    wait_ticks(10);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy_async", busy, 0);
    check("t6_start_async", eng_start, 0);
    check("t6_rsp_async", rsp_valid, 0);
    @(negedge clk);
    eng_q.delete(); last_end = 0; m_rr = 0; m_cache_valid = 0;
    rc0 = rsp_count;
    rst_n = 1'b1;
    miss_txn(1, 0, $urandom, 1, "t6_post");
    check("t6_start_tick", last_start, MIN_GAP);
    check("t6_rsp_count", rsp_count - rc0, 1);

    for (int it = 0; it < 8; it++) begin
      who = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && m_cache_valid && tick_count - m_cache_tick < 60) begin
        wait_ticks(int'($urandom_range(0, 15)));
        hit_txn(who, "rnd_hit");
      end else begin
        while (m_cache_valid && tick_count - m_cache_tick <= 110) @(negedge clk);
        wait_ticks(int'($urandom_range(0, 10)));
        miss_txn(who, int'($urandom_range(0, 3)), $urandom, 3, "rnd_miss");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
